// File: rtl/avr_serial_rx_if.sv
// avr_serial_rx_if: one-entry valid/ready byte channel from the AVR receiver to FPGA logic
interface avr_serial_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/avr_serial_rx.sv
// avr_serial_rx: 8N1 receiver for the AVR transmit line, gated by cclk readiness,
// with a one-entry holding register, framing-error and overrun pulses.
module avr_serial_rx #(
  parameter int CLK_PER_BIT       = 100,
  parameter int CCLK_READY_CYCLES = 512
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cclk,
  input  logic            rx,
  avr_serial_rx_if.master out,
  output logic            frame_err,
  output logic            overrun,
  output logic            rx_active
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int RW = $clog2(CCLK_READY_CYCLES + 1);
  typedef enum logic [2:0] {WAIT_CCLK, IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        state_q;
  logic [1:0]    rx_sync_q, cclk_sync_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rdy_cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          valid_q, frame_err_q, overrun_q, rx_active_q;
  logic          rxs, cclk_s, half, bit_end, byte_done;
  always_comb begin
    rxs       = rx_sync_q[1];
    cclk_s    = cclk_sync_q[1];
    half      = cnt_q == CW'(CLK_PER_BIT / 2 - 1);
    bit_end   = cnt_q == CW'(CLK_PER_BIT - 1);
    byte_done = state_q == STOP && cclk_s && bit_end && rxs;
  end
  // Synchronizers preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_sync_q   <= 2'b11;
      cclk_sync_q <= 2'b11;
    end else begin
      rx_sync_q   <= {rx_sync_q[0], rx};
      cclk_sync_q <= {cclk_sync_q[0], cclk};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= WAIT_CCLK;
      cnt_q       <= '0;
      rdy_cnt_q   <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state_q != WAIT_CCLK && !cclk_s) begin
        state_q     <= WAIT_CCLK;
        rdy_cnt_q   <= '0;
        rx_active_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_CCLK:
            if (!cclk_s) rdy_cnt_q <= '0;
            else if (rdy_cnt_q == RW'(CCLK_READY_CYCLES - 1)) begin
              state_q   <= IDLE;
              rdy_cnt_q <= '0;
            end else rdy_cnt_q <= rdy_cnt_q + 1'b1;
          IDLE:
            if (!rxs) begin
              state_q     <= START;
              cnt_q       <= '0;
              rx_active_q <= 1'b1;
            end
          START:
            if (half) begin
              cnt_q       <= '0;
              bit_q       <= '0;
              state_q     <= rxs ? IDLE : DATA;
              rx_active_q <= !rxs;
            end else cnt_q <= cnt_q + 1'b1;
          DATA:
            if (bit_end) begin
              cnt_q   <= '0;
              shift_q <= {rxs, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= STOP;
            end else cnt_q <= cnt_q + 1'b1;
          STOP:
            if (bit_end) begin
              cnt_q       <= '0;
              rx_active_q <= 1'b0;
              frame_err_q <= !rxs;
              state_q     <= rxs ? IDLE : BREAK;
            end else cnt_q <= cnt_q + 1'b1;
          BREAK:
            if (rxs) state_q <= IDLE;
          default: state_q <= WAIT_CCLK;
        endcase
      end
    end
  // A same-edge drain frees the slot, so the new byte replaces the old without overrun.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || out.data_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else overrun_q <= 1'b1;
      end else if (valid_q && out.data_ready) valid_q <= 1'b0;
    end
  assign out.data       = data_q;
  assign out.data_valid = valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign rx_active      = rx_active_q;
endmodule

// File: tb/tb_avr_serial_rx.sv
// tb_avr_serial_rx: directed and randomized 8N1 frames checked against a byte-level reference.
module tb_avr_serial_rx;
  localparam int N   = 8;
  localparam int RDY = 512;
  localparam int LAT = 3 + N / 2 + 9 * N;
  logic clk = 1'b0, rst_n = 1'b0, cclk = 1'b1, rx = 1'b1;
  logic frame_err, overrun, rx_active;
  avr_serial_rx_if bus ();
  avr_serial_rx #(.CLK_PER_BIT(N), .CCLK_READY_CYCLES(RDY)) dut (
    .clk(clk), .rst_n(rst_n), .cclk(cclk), .rx(rx), .out(bus),
    .frame_err(frame_err), .overrun(overrun), .rx_active(rx_active)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  int fe_n = 0, ovr_n = 0, act_n = 0, rise_cyc = -1;
  int fe0, ov0, a0, n0;
  logic vprev = 1'b0;
  logic [7:0] got[$];
  logic [7:0] sent[$];
  logic [7:0] a, b, c;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.data_valid && bus.data_ready) got.push_back(bus.data);
      fe_n  += int'(frame_err);
      ovr_n += int'(overrun);
      act_n += int'(rx_active);
      if (bus.data_valid && !vprev) rise_cyc = cyc;
      vprev = bus.data_valid;
    end else vprev = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f  = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(N);
    end
    rx = 1'b1;
  endtask
  function automatic logic [7:0] last_got();
    return got.size() > 0 ? got[got.size()-1] : 8'hxx;
  endfunction
  initial begin
    bus.data_ready = 1'b0;
    tick(3);
    check("rst_data", bus.data, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rx_active", rx_active, 0);
    rst_n = 1'b1;
    tick(300);
    cclk = 1'b0;
    tick(4);
    cclk = 1'b1;
    send(8'h55, 1'b1);
    tick(N);
    check("gate_no_valid", bus.data_valid, 0);
    check("gate_no_active", act_n, 0);
    tick(RDY + 50);
    send(8'h55, 1'b1);
    tick(2);
    check("gate_data", bus.data, 8'h55);
    check("gate_valid", bus.data_valid, 1);
    check("gate_latency", rise_cyc - t0, LAT);
    bus.data_ready = 1'b1;
    tick(1);
    check("drain_valid", bus.data_valid, 0);
    check("drain_byte", last_got(), 8'h55);
    got.delete();
    sent = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    repeat (6) sent.push_back(8'($urandom));
    fe0 = fe_n;
    ov0 = ovr_n;
    foreach (sent[i]) send(sent[i], 1'b1);
    tick(2);
    check("b2b_count", got.size(), sent.size());
    foreach (sent[i]) check($sformatf("b2b_byte%0d", i), got.size() > i ? got[i] : 8'hxx, sent[i]);
    check("b2b_no_overrun", ovr_n - ov0, 0);
    check("b2b_no_frame_err", fe_n - fe0, 0);
    bus.data_ready = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    ov0 = ovr_n;
    send(a, 1'b1);
    send(b, 1'b1);
    tick(2);
    check("ovr_data_kept", bus.data, a);
    check("ovr_valid", bus.data_valid, 1);
    check("ovr_one_pulse", ovr_n - ov0, 1);
    bus.data_ready = 1'b1;
    tick(1);
    bus.data_ready = 1'b0;
    tick(1);
    check("ovr_drained", bus.data_valid, 0);
    check("ovr_drained_byte", last_got(), a);
    a = 8'($urandom);
    b = ~a;
    send(a, 1'b1);
    tick(2);
    check("fill_first", bus.data, a);
    ov0 = ovr_n;
    fork
      send(b, 1'b1);
      begin
        tick(LAT - 1);
        bus.data_ready = 1'b1;
        tick(1);
        bus.data_ready = 1'b0;
      end
    join
    tick(2);
    check("fill_data", bus.data, b);
    check("fill_valid", bus.data_valid, 1);
    check("fill_no_overrun", ovr_n - ov0, 0);
    check("fill_consumed_old", last_got(), a);
    bus.data_ready = 1'b1;
    tick(2);
    fe0 = fe_n;
    n0  = got.size();
    send(8'h81, 1'b0);
    rx = 1'b0;
    a0 = act_n;
    tick(50 * N);
    check("brk_one_frame_err", fe_n - fe0, 1);
    check("brk_no_byte", got.size(), n0);
    check("brk_no_valid", bus.data_valid, 0);
    check("brk_stays_inactive", act_n - a0, 0);
    rx = 1'b1;
    tick(4);
    c = 8'($urandom);
    send(c, 1'b1);
    tick(2);
    check("brk_recover_byte", last_got(), c);
    check("brk_recover_count", got.size(), n0 + 1);
    a0  = act_n;
    fe0 = fe_n;
    n0  = got.size();
    rx  = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * N);
    check("glitch_active_short", (act_n - a0 > 0) && (act_n - a0 <= N / 2 + 2), 1);
    check("glitch_no_frame_err", fe_n - fe0, 0);
    check("glitch_no_byte", got.size(), n0);
    fe0 = fe_n;
    ov0 = ovr_n;
    n0  = got.size();
    fork
      send(8'($urandom), 1'b1);
      begin
        tick(3 + N / 2 + 3 * N + N / 2);
        check("abort_active_before", rx_active, 1);
        cclk = 1'b0;
        tick(1);
        cclk = 1'b1;
        tick(4);
        check("abort_inactive", rx_active, 0);
      end
    join
    tick(2);
    check("abort_no_frame_err", fe_n - fe0, 0);
    check("abort_no_overrun", ovr_n - ov0, 0);
    check("abort_no_byte", got.size(), n0);
    tick(RDY + 20);
    c = 8'($urandom);
    send(c, 1'b1);
    tick(2);
    check("abort_reenabled", last_got(), c);
    bus.data_ready = 1'b0;
    c = 8'($urandom) | 8'h01;
    send(c, 1'b1);
    tick(2);
    check("areset_pre_valid", bus.data_valid, 1);
    fork
      send(8'($urandom), 1'b1);
      begin
        tick(30);
        rst_n = 1'b0;
        #1;
        check("areset_data", bus.data, 0);
        check("areset_valid", bus.data_valid, 0);
        check("areset_frame_err", frame_err, 0);
        check("areset_overrun", overrun, 0);
        check("areset_rx_active", rx_active, 0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avr_serial_rx.md
Name: avr_serial_rx

Overview:
Receives 8N1 serial bytes that the AVR drives on its transmit line (avr_tx) and presents them to FPGA logic through a one-entry valid/ready holding register. It is the receiving end of the AVR serial link, paired with the FPGA transmitter that drives avr_rx. The block stays idle until the AVR signals readiness on cclk. It flags framing errors and overruns.

Parameters:
CLK_PER_BIT, 100, clk cycles per serial bit (50 MHz / 500 kbaud); minimum 4.
CCLK_READY_CYCLES, 512, consecutive clk cycles that cclk must be high before reception is enabled.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cclk  input  1  AVR configuration clock/ready indicator; high means the AVR is ready
rx  input  1  serial line from the AVR (avr_tx); idles high
data  output  8  received byte; valid while data_valid is high
data_valid  output  1  holding register is full
data_ready  input  1  consumer accepts the byte when data_valid and data_ready are both high at a clk edge
frame_err  output  1  one-cycle pulse: stop bit was sampled low
overrun  output  1  one-cycle pulse: a byte completed while the holding register was full and not being drained
rx_active  output  1  high in the START, DATA and STOP states

Behaviour:
- Reset (async, rst_n low):
  - data=0, data_valid=0, frame_err=0, overrun=0, rx_active=0.
  - State=WAIT_CCLK; cclk counter=0; bit counter=0.
  - Synchronizer flops are preset to 1.
- rx passes through a 2-flop synchronizer; all decisions below use the synchronized value (rxs). cclk is synchronized the same way.
- WAIT_CCLK:
  - Counter increments while cclk is high and clears to 0 when cclk is low.
  - When the count reaches CCLK_READY_CYCLES-1 with cclk still high, go to IDLE.
- Any state other than WAIT_CCLK: cclk low for 1 synchronized cycle → WAIT_CCLK. Any in-progress frame is abandoned with no error pulse. The holding register is untouched.
- IDLE: rxs=0 → START, and the sample counter loads 0.
- START:
  - At counter = CLK_PER_BIT/2 - 1, sample rxs.
  - rxs=0 → DATA, counter reset, bit index 0.
  - rxs=1 → glitch; return to IDLE with no flag.
- DATA:
  - Sample every CLK_PER_BIT cycles after the start mid-point, i.e. at the middle of each bit.
  - Bits arrive LSB first into a shift register.
  - After bit 7 → STOP.
- STOP (mid-bit sample):
  - rxs=1: byte complete; deliver it to the holding register (rules below); go to IDLE.
  - rxs=0: pulse frame_err for one cycle; discard the byte; go to BREAK.
- BREAK: wait until rxs=1, then IDLE. A held-low line produces exactly one frame_err.
- Holding register rules, evaluated at the byte-complete edge:
  - data_valid=0: load data; data_valid=1 on the next cycle (latency: 1 clk after the stop mid-sample edge).
  - data_valid=1 and data_ready=1 in the same cycle: old byte is consumed, new byte is loaded, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: keep the old byte, drop the new one, pulse overrun for one cycle.
- Without a byte completion, data_valid=1 and data_ready=1 clears data_valid on the next cycle; data holds its value.
- data_ready while data_valid=0 is ignored.
- Counter width is $clog2(CLK_PER_BIT); the counter wraps to 0 at CLK_PER_BIT-1.
- The minimum inter-frame gap is 0: a start bit may immediately follow a stop mid-sample once rxs is low in IDLE.

Test Plan:
- Readiness gating: CLK_PER_BIT=8; toggle cclk low at cycle 300, then hold it high; send 0x55 before 512 continuous high cycles → no data_valid. Resend after the threshold → data=0x55, data_valid=1 exactly 1 clk after the stop mid-sample.
- Back-to-back bytes: send 0xA5, 0x3C, 0xFF, 0x00 with no gap and data_ready held 1 → each byte appears in order; no overrun; no frame_err.
- Overrun: data_ready=0; send 0x12 then 0x34 → data stays 0x12 and overrun pulses for exactly 1 cycle at the second byte's stop. Then assert data_ready for 1 cycle → data_valid=0.
- Simultaneous drain and fill: data_valid=1 with 0x12; assert data_ready on the same edge that 0x34 completes → data=0x34, data_valid stays 1, no overrun.
- Framing error and glitch: send 0x81 with stop bit low, then hold rx low for 50 bit times → one frame_err pulse, no data_valid, return to IDLE only after rx goes high. Send a 2-cycle low glitch → no state beyond START, rx_active falls within CLK_PER_BIT/2+2 cycles.
- Mid-frame aborts: drop cclk during bit 3 → WAIT_CCLK, rx_active=0, no flags. Assert rst_n=0 mid-frame → all outputs 0 immediately (asynchronous).
